// File: rtl/lc3_debug_pkg.sv
// Shared definitions for lc3 debug-trace capture: trigger state, record layout
// and the word order used when a record is streamed out.
package lc3_debug_pkg;

  localparam logic [5:0] FETCH_STATE  = 6'd18;
  localparam int         RECORD_WORDS = 11;
  localparam int         RECORD_BITS  = 156;

  localparam logic [3:0] WORD_INSTR = 4'd0;
  localparam logic [3:0] WORD_CUR   = 4'd1;
  localparam logic [3:0] WORD_NEXT  = 4'd2;
  localparam logic [3:0] WORD_R0    = 4'd3;
  localparam logic [3:0] WORD_LAST  = 4'd10;

  typedef struct packed {
    logic [15:0]      instr;
    logic [5:0]       cur;
    logic [5:0]       next;
    logic [7:0][15:0] regs;
  } trace_rec_t;

  function automatic logic [15:0] rec_word(input trace_rec_t rec, input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      WORD_INSTR: w = rec.instr;
      WORD_CUR:   w = {10'b0, rec.cur};
      WORD_NEXT:  w = {10'b0, rec.next};
      4'd3:       w = rec.regs[0];
      4'd4:       w = rec.regs[1];
      4'd5:       w = rec.regs[2];
      4'd6:       w = rec.regs[3];
      4'd7:       w = rec.regs[4];
      4'd8:       w = rec.regs[5];
      4'd9:       w = rec.regs[6];
      4'd10:      w = rec.regs[7];
      default:    w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lc3_trace_fifo.sv
// Synchronous record FIFO; head entry is read combinationally from storage so a
// push behind it never disturbs the word currently being streamed.
module lc3_trace_fifo #(
  parameter int WIDTH = 156,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  // Storage is left unreset; contents are only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/lc3_trace_capture.sv
// Snapshots lc3 architectural state on each FETCH entry and streams the buffered
// records out as 11 sixteen-bit words over a valid/ready port.
module lc3_trace_capture #(
  parameter int         DEPTH       = 16,
  parameter logic [5:0] FETCH_STATE = lc3_debug_pkg::FETCH_STATE,
  parameter int         CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [15:0]            debug_instruction,
  input  logic [5:0]             debug_current_state,
  input  logic [5:0]             debug_next_state,
  input  logic [127:0]           debug_reg_read,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       overflow_count
);

  import lc3_debug_pkg::*;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic                   r_prev_fetch;
  logic [3:0]             r_word_idx;
  logic [CNT_W-1:0]       r_overflow_count;

  logic                   w_capture_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_xfer;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_level;
  logic [0:0]             w_state;
  trace_rec_t             w_new_rec;
  trace_rec_t             w_head_rec;
  logic [RECORD_BITS-1:0] w_head_bits;

  assign w_new_rec.instr = debug_instruction;
  assign w_new_rec.cur   = debug_current_state;
  assign w_new_rec.next  = debug_next_state;
  assign w_new_rec.regs  = debug_reg_read;
  assign w_head_rec      = trace_rec_t'(w_head_bits);

  // Rising-edge detect on next_state==FETCH so a held FETCH captures once.
  assign w_capture_req = enable && (debug_next_state == FETCH_STATE) && !r_prev_fetch;
  assign w_xfer        = out_valid && out_ready;
  assign w_pop         = w_xfer && (r_word_idx == WORD_LAST);
  // A full FIFO still takes the capture when the head leaves in the same cycle.
  assign w_push        = w_capture_req && (!w_full || w_pop);

  lc3_trace_fifo #(
    .WIDTH (RECORD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (RECORD_BITS'(w_new_rec)),
    .o_head  (w_head_bits),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The serializer is in SEND exactly while a record is buffered, which keeps
  // capture-to-valid latency at one edge and lets reset drop valid at once.
  always_comb begin
    if (w_empty) begin
      w_state = ST_IDLE;
    end else begin
      w_state = ST_SEND;
    end
  end

  assign out_valid = (w_state == ST_SEND);
  assign out_last  = out_valid && (r_word_idx == WORD_LAST);

  // Word mux from the registered head entry; forced to zero when idle.
  always_comb begin
    if (out_valid) begin
      out_data = rec_word(w_head_rec, r_word_idx);
    end else begin
      out_data = 16'h0000;
    end
  end

  // Trigger history and word index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_fetch <= 1'b0;
      r_word_idx   <= 4'd0;
    end else begin
      r_prev_fetch <= (debug_next_state == FETCH_STATE);
      if (w_xfer) begin
        if (r_word_idx == WORD_LAST) begin
          r_word_idx <= 4'd0;
        end else begin
          r_word_idx <= r_word_idx + 4'd1;
        end
      end
    end
  end

  // Count captures that found no room, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow_count <= '0;
    end else if (w_capture_req && !w_push && (r_overflow_count != {CNT_W{1'b1}})) begin
      r_overflow_count <= r_overflow_count + CNT_W'(1);
    end
  end

  assign level          = w_level;
  assign full           = w_full;
  assign empty          = w_empty;
  assign overflow_count = r_overflow_count;

endmodule
